// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline register and its helpers.
package pipe_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned CNT_W_DEF  = 16;

  // Default NOP payload for a DATA_W_DEF-wide stage.
  localparam logic [DATA_W_DEF-1:0] NOP_DEF = '0;

  // Occupancy of the stage; ST_SKID is only reachable with the skid entry built in.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc, stick at all-ones, clear on rst or clr.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with NOP bubble insertion,
// sticky delay-slot flag and a saturating bubble counter.
// Optional macro PIPE_SKID_EN adds a one-entry skid buffer so in_ready is
// decoded from state only (no combinational path from out_ready).
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned          DATA_W  = DATA_W_DEF,
  parameter logic [DATA_W-1:0]    NOP_VAL = {DATA_W{1'b0}},
  parameter int unsigned          CNT_W   = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_ds_next,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_ds,
  output logic [CNT_W-1:0]  bubble_cnt,
  input  logic              cnt_clr
);

  pipe_state_e       state;
  pipe_state_e       state_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic              ds_nxt;
  logic              accept;
  logic              drain;
  logic              bubble;

`ifdef PIPE_SKID_EN
  logic [DATA_W-1:0] skid_data;
  logic [DATA_W-1:0] skid_nxt;
  logic              skid_valid;

  assign skid_valid = (state == ST_SKID);
  assign in_ready   = !skid_valid;
`else
  assign in_ready   = out_ready || !out_valid;
`endif

  assign out_valid = (state != ST_EMPTY);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  // State, payload and sideband registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_EMPTY;
      out_data <= NOP_VAL;
      out_ds   <= 1'b0;
    end else begin
      state    <= state_nxt;
      out_data <= data_nxt;
      out_ds   <= ds_nxt;
    end
  end

`ifdef PIPE_SKID_EN
  // Skid payload; only meaningful while in ST_SKID, so no reset needed.
  always_ff @(posedge clk) begin
    skid_data <= skid_nxt;
  end
`endif

  // Next-state, next-payload and bubble decision; flush beats transfers.
  always_comb begin
    state_nxt = state;
    data_nxt  = out_data;
    ds_nxt    = out_ds;
    bubble    = 1'b0;
`ifdef PIPE_SKID_EN
    skid_nxt  = skid_data;
`endif
    if (flush) begin
      state_nxt = ST_EMPTY;
      data_nxt  = NOP_VAL;
      ds_nxt    = 1'b0;
    end else begin
      if (accept) begin
        ds_nxt = in_ds_next;
      end
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            state_nxt = ST_FULL;
            data_nxt  = in_data;
          end else if (out_ready) begin
            data_nxt = NOP_VAL;
            bubble   = 1'b1;
          end
        end
        ST_FULL: begin
          if (drain && accept) begin
            data_nxt = in_data;
          end else if (drain) begin
            state_nxt = ST_EMPTY;
            data_nxt  = NOP_VAL;
            bubble    = 1'b1;
          end
`ifdef PIPE_SKID_EN
          else if (accept) begin
            state_nxt = ST_SKID;
            skid_nxt  = in_data;
          end
`endif
        end
`ifdef PIPE_SKID_EN
        ST_SKID: begin
          if (drain) begin
            state_nxt = ST_FULL;
            data_nxt  = skid_data;
          end
        end
`endif
        default: begin
          state_nxt = ST_EMPTY;
          data_nxt  = NOP_VAL;
        end
      endcase
    end
  end

  // Performance counter of inserted bubbles.
  sat_counter #(
    .W (CNT_W)
  ) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (bubble),
    .count (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg (DATA_W=32, CNT_W=4).
module tb_pipe_stage_reg;

  localparam int unsigned DW  = 32;
  localparam int unsigned CW  = 4;
  localparam logic [31:0] NOP = 32'h1357_9BDF;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_ds_next;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_ds;
  logic [CW-1:0] bubble_cnt;
  logic          cnt_clr;

  int n_cmp;
  int n_mis;

  pipe_stage_reg #(
    .DATA_W  (DW),
    .NOP_VAL (NOP),
    .CNT_W   (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_ds_next (in_ds_next),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ds     (out_ds),
    .bubble_cnt (bubble_cnt),
    .cnt_clr    (cnt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] d);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".data"}, out_data, d);
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    rst = 1'b1; flush = 1'b0; cnt_clr = 1'b0;
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_ds_next = 1'b1; out_ready = 1'b1;

    // Reset with a pending accept on the inputs.
    tick(); tick();
    chk_out("reset", 1'b0, NOP);
    chk("reset.ds", 32'(out_ds), 32'd0);
    chk("reset.cnt", 32'(bubble_cnt), 32'd0);
    rst = 1'b0;

    // Streaming four back-to-back payloads; last one marks a delay slot.
    in_ds_next = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_data = 32'(i);
      in_ds_next = (i == 4);
      tick();
      chk_out($sformatf("stream%0d", i), 1'b1, 32'(i));
    end
    chk("stream.cnt", 32'(bubble_cnt), 32'd0);
    chk("stream.ds", 32'(out_ds), 32'd1);

    // Upstream stall: three bubbles, delay-slot flag is sticky.
    in_valid = 1'b0; in_ds_next = 1'b0; in_data = 32'hFFFF_0000;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_out($sformatf("ustall%0d", i), 1'b0, NOP);
      chk($sformatf("ustall%0d.cnt", i), 32'(bubble_cnt), 32'(i));
    end
    chk("ustall.ds", 32'(out_ds), 32'd1);

    // Downstream stall holding 0xA5.
    in_valid = 1'b1; in_data = 32'hA5;
    tick();
    chk_out("fill", 1'b1, 32'hA5);
    out_ready = 1'b0; in_data = 32'hB6;
    #1;
`ifdef PIPE_SKID_EN
    chk("skid.rdy0", 32'(in_ready), 32'd1);
    tick();
    chk("skid.rdy1", 32'(in_ready), 32'd0);
    in_data = 32'hC7;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk_out($sformatf("dstall%0d", i), 1'b1, 32'hA5);
      chk($sformatf("dstall%0d.rdy", i), 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk_out("skid.drain", 1'b1, 32'hB6);
    chk("skid.rdy2", 32'(in_ready), 32'd1);
    tick();
`else
    for (int i = 1; i <= 5; i++) begin
      chk($sformatf("dstall%0d.rdy", i), 32'(in_ready), 32'd0);
      tick();
      chk_out($sformatf("dstall%0d", i), 1'b1, 32'hA5);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
`endif
    chk_out("release", 1'b0, NOP);
    chk("release.cnt", 32'(bubble_cnt), 32'd4);

    // Empty with downstream stalled: hold, no count, ready to accept.
    out_ready = 1'b0;
    tick();
    chk("idle.cnt", 32'(bubble_cnt), 32'd4);
    chk("idle.rdy", 32'(in_ready), 32'd1);

    // Flush kills the held entry and the simultaneous accept.
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h55; in_ds_next = 1'b1;
    tick();
    chk_out("preflush", 1'b1, 32'h55);
    chk("preflush.ds", 32'(out_ds), 32'd1);
    flush = 1'b1; in_data = 32'h77;
    tick();
    flush = 1'b0; in_valid = 1'b0; in_ds_next = 1'b0;
    chk_out("flush", 1'b0, NOP);
    chk("flush.ds", 32'(out_ds), 32'd0);
    chk("flush.cnt", 32'(bubble_cnt), 32'd4);

    // Saturation: 20 more bubbles pin the 4-bit counter at 0xF.
    for (int i = 0; i < 20; i++) tick();
    chk("sat.cnt", 32'(bubble_cnt), 32'hF);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr.cnt", 32'(bubble_cnt), 32'd0);
    tick();
    chk("postclr.cnt", 32'(bubble_cnt), 32'd1);

    // Reset during an accept drops it.
    in_valid = 1'b1; in_data = 32'h99; in_ds_next = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk_out("midrst", 1'b0, NOP);
    chk("midrst.ds", 32'(out_ds), 32'd0);
    chk("midrst.cnt", 32'(bubble_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register. Successor to the fixed IF/ID/EX stage registers.
- Carries an opaque payload of DATA_W bits using a valid/ready handshake instead of a 6-bit stall vector.
- Inserts NOP bubbles when the upstream stage stalls and the downstream stage does not.
- Tracks the sticky delay-slot sideband flag and counts inserted bubbles for performance analysis.
- Instantiated between every pair of stages (ID/EX, EX/MEM, MEM/WB).

Parameters:
- DATA_W, 32: payload width in bits (aluop, alusel, operands, wd, wreg, inst, excepttype and pc are concatenated by the instantiating stage).
- NOP_VAL, {DATA_W{1'b0}}: payload value driven on reset, flush and bubble.
- CNT_W, 16: width of the bubble counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- flush  in  1  exception/eret flush; kills the held and incoming entry
- in_valid  in  1  upstream presents a valid payload
- in_ready  out  1  stage can accept in_data this cycle
- in_data  in  DATA_W  upstream payload
- in_ds_next  in  1  next instruction sits in a delay slot (sideband)
- out_valid  out  1  out_data holds a real instruction
- out_ready  in  1  downstream accepts out_data this cycle
- out_data  out  DATA_W  registered payload
- out_ds  out  1  registered delay-slot flag for upstream decode
- bubble_cnt  out  CNT_W  saturating count of inserted bubbles
- cnt_clr  in  1  synchronous clear of bubble_cnt

Behaviour:
- Clock and reset: reset rst, synchronous, active-high; clock clk.
- Reset values: out_valid=0, out_data=NOP_VAL, out_ds=0, bubble_cnt=0. Any internal skid entry is invalid.
- Transfers:
  - Accept: in_valid && in_ready.
  - Drain: out_valid && out_ready.
  - Latency from accept to appearance on out_data is 1 cycle.
- States: EMPTY (out_valid=0), FULL (out_valid=1); SKID exists only with the optional feature.
- EMPTY:
  - accept -> FULL, out_data<=in_data.
  - No accept while downstream is advancing (out_ready=1) -> remain EMPTY, out_data<=NOP_VAL, bubble_cnt++.
  - No accept while out_ready=0 -> hold; no count.
- FULL:
  - Drain with simultaneous accept -> stay FULL with the new data.
  - Drain without accept -> EMPTY, out_data<=NOP_VAL, bubble_cnt++.
  - No drain -> hold out_data unchanged. in_ready=0 (base build).
- Base build: in_ready = out_ready || !out_valid (combinational).
- out_ds: loads in_ds_next only on accept. It holds through bubbles and stalls, and is not cleared by bubble insertion. It is cleared by rst and flush.
- Flush priority:
  - Ordering is rst > flush > transfer logic.
  - Flush forces EMPTY, out_data=NOP_VAL, out_ds=0. Any accept in the same cycle is discarded.
  - Flush does not increment bubble_cnt.
- bubble_cnt:
  - Saturates at all-ones; no wrap.
  - cnt_clr has priority over increment in the same cycle.
  - rst clears it; flush does not.
- Payload: no bit of in_data is interpreted; width is exactly DATA_W.
- Reset asserted mid-transfer: the pending accept is dropped and the state is as after reset.

Optional Feature:
- Macro: PIPE_SKID_EN.
- Defined:
  - Adds a one-entry skid register and the SKID state, so in_ready becomes registered: in_ready = !skid_valid.
  - FULL with accept and no drain -> SKID; in_data goes to the skid entry.
  - SKID with drain -> FULL, out_data<=skid entry.
  - Sustains full throughput with no combinational path from out_ready to in_ready.
  - Flush empties both entries.
- Undefined:
  - No skid storage; in_ready is combinational as in the base build.

Decomposition:
- Shared package/header (pipe_pkg): state encoding localparams (ST_EMPTY, ST_FULL, ST_SKID), default NOP payload constant, CNT_W default.
- One natural sub-module, sat_counter (CNT_W-wide saturating counter with clear and increment), reused by other performance counters.
- Everything else stays in pipe_stage_reg.

Test Plan:
1. Reset: assert rst for 2 cycles with in_valid=1 and in_data=32'hDEADBEEF -> out_valid=0, out_data=NOP_VAL, out_ds=0, bubble_cnt=0.
2. Streaming: out_ready=1, 4 back-to-back accepts of 1,2,3,4 -> out_data = 1,2,3,4 on consecutive cycles, each 1 cycle after its accept; bubble_cnt unchanged.
3. Upstream stall: in_valid=0 for 3 cycles with out_ready=1 -> out_valid=0 and out_data=NOP_VAL for 3 cycles; bubble_cnt=3. out_ds keeps its prior value of 1.
4. Downstream stall: FULL with data 32'hA5, out_ready=0 for 5 cycles -> out_data stays 32'hA5 and in_ready=0 (base build); with PIPE_SKID_EN, one more accept succeeds and in_ready drops 1 cycle later.
5. Flush with accept: flush=1 while in_valid=1 and in_data=32'h77 -> next cycle out_valid=0, out_data=NOP_VAL, out_ds=0; bubble_cnt unchanged.
6. Saturation: CNT_W=4, force 20 bubbles -> bubble_cnt=4'hF; cnt_clr and a bubble in the same cycle -> bubble_cnt=0.
